// File: rtl/marmot_sram_dbg_reader.sv
// ============================================================================
// marmot_sram_dbg_reader : Wishbone debug reader for cache SRAM port 1
// Revision: 1.0
// ============================================================================
`default_nettype none

module marmot_sram_dbg_reader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          REGION_LSB = 16,
  parameter int          NUM_BANKS  = 8,
  parameter int          BANK_W     = 3,
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 9,
  parameter int          READ_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dbg_en,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  output logic [NUM_BANKS-1:0]        ram_csb1,
  output logic [ADDR_W-1:0]           ram_addr1,
  input  logic [NUM_BANKS*DATA_W-1:0] ram_rdata1
);

  localparam int ROW_LSB  = (DATA_W == 64) ? 3 : 2;
  localparam int BANK_LSB = ROW_LSB + ADDR_W;
  localparam int CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W+1)'(NUM_BANKS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t               state, state_nxt;
  logic                 ack_nxt;
  logic [31:0]          dat_nxt;
  logic [NUM_BANKS-1:0] csb_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BANK_W-1:0]    bank, bank_nxt;
  logic                 half, half_nxt;

  logic                 hit, bank_ok, req_half;
  logic [BANK_W-1:0]    req_bank;
  logic [ADDR_W-1:0]    req_row;
  logic [DATA_W-1:0]    rd_word;
  logic [63:0]          rd_word64;
  logic [31:0]          rd_slice;
  logic                 unused_bits;

  assign hit      = (wbs_adr_i[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB]);
  assign req_row  = wbs_adr_i[ROW_LSB +: ADDR_W];
  assign req_bank = wbs_adr_i[BANK_LSB +: BANK_W];
  assign req_half = (DATA_W == 64) && wbs_adr_i[2];
  assign bank_ok  = ({1'b0, req_bank} < BANK_LIMIT);

  assign unused_bits = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i};

  // Bank mux on the latched bank; half is only ever set for 64-bit macros.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank == BANK_W'(b)) rd_word = ram_rdata1[b*DATA_W +: DATA_W];
    end
  end

  assign rd_word64 = 64'(rd_word);
  assign rd_slice  = half ? rd_word64[63:32] : rd_word64[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ram_csb1  <= '1;
      ram_addr1 <= '0;
      cnt       <= '0;
      bank      <= '0;
      half      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wbs_ack_o <= ack_nxt;
      wbs_dat_o <= dat_nxt;
      ram_csb1  <= csb_nxt;
      ram_addr1 <= addr_nxt;
      cnt       <= cnt_nxt;
      bank      <= bank_nxt;
      half      <= half_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    dat_nxt   = '0;
    csb_nxt   = '1;
    addr_nxt  = ram_addr1;
    cnt_nxt   = cnt;
    bank_nxt  = bank;
    half_nxt  = half;
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && hit) begin
          if (!wbs_we_i && dbg_en && bank_ok) begin
            state_nxt = ISSUE;
            addr_nxt  = req_row;
            bank_nxt  = req_bank;
            half_nxt  = req_half;
            for (int b = 0; b < NUM_BANKS; b++) begin
              if (req_bank == BANK_W'(b)) csb_nxt[b] = 1'b0;
            end
          end else begin
            // Writes, disabled or out-of-range accesses complete with zero data.
            state_nxt = ACK;
            ack_nxt   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!wbs_cyc_i) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = ACK;
          ack_nxt   = 1'b1;
          dat_nxt   = rd_slice;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire
